// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/rf_mp_scoreboard_if.sv
// Register-file bus: issue side (reads, scoreboard set, debug) and writeback side (writes).
interface rf_mp_scoreboard_if
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic [NREG-1:0]     busy;
  logic [AW-1:0]       dbg_sel;
  logic [XLEN-1:0]     dbg_data;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rd_addr, sb_set_en, sb_set_addr, dbg_sel,
    input  rd_data, rd_busy, busy, dbg_data
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rd_addr, sb_set_en, sb_set_addr, dbg_sel,
    output rd_data, rd_busy, busy, dbg_data
  );
endinterface

// File: rtl/rf_bypass_mux.sv
// One read port's source select: zero register, then wr1, then wr0, then stored value.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] stored_i,
  input  logic            wr0_en_i,
  input  logic [AW-1:0]   wr0_addr_i,
  input  logic [XLEN-1:0] wr0_data_i,
  input  logic            wr1_en_i,
  input  logic [AW-1:0]   wr1_addr_i,
  input  logic [XLEN-1:0] wr1_data_i,
  output logic [XLEN-1:0] data_o,
  output logic            hit_o
);
  logic is_zero;
  logic hit0;
  logic hit1;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr_i == AW'(ZERO_IDX));
    hit1    = wr1_en_i && (wr1_addr_i == rd_addr_i);
    hit0    = wr0_en_i && (wr0_addr_i == rd_addr_i);
    data_o  = stored_i;
    hit_o   = 1'b0;
    if (is_zero) begin
      data_o = '0;
    end else if (hit1) begin
      data_o = wr1_data_i;
      hit_o  = 1'b1;
    end else if (hit0) begin
      data_o = wr0_data_i;
      hit_o  = 1'b1;
    end
  end
endmodule

// File: rtl/rf_mp_scoreboard.sv
// Two-write, NRD-read register file with same-cycle bypass and a per-register busy scoreboard.
module rf_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  rf_mp_scoreboard_if.slave   bus_if
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [NRD*XLEN-1:0] rd_data_w;
  logic [NRD-1:0]      rd_busy_w;

  function automatic logic writable(input logic [AW-1:0] idx);
    return !((ZERO_REG != 0) && (idx == AW'(ZERO_IDX)));
  endfunction

  // wr1 is applied last so it overrides wr0 on an address collision
  always_comb begin
    regs_d = regs_q;
    if (bus_if.wr0_en && writable(bus_if.wr0_addr)) regs_d[bus_if.wr0_addr] = bus_if.wr0_data;
    if (bus_if.wr1_en && writable(bus_if.wr1_addr)) regs_d[bus_if.wr1_addr] = bus_if.wr1_data;
  end

  // A new issue to the same index outranks a completing writeback
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if ((bus_if.wr0_en && bus_if.wr0_addr == AW'(i)) ||
          (bus_if.wr1_en && bus_if.wr1_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (bus_if.sb_set_en && bus_if.sb_set_addr == AW'(i) && writable(AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            hit;

    assign ra = bus_if.rd_addr[k*AW +: AW];

    rf_bypass_mux #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .rd_addr_i  (ra),
      .stored_i   (regs_q[ra]),
      .wr0_en_i   (bus_if.wr0_en),
      .wr0_addr_i (bus_if.wr0_addr),
      .wr0_data_i (bus_if.wr0_data),
      .wr1_en_i   (bus_if.wr1_en),
      .wr1_addr_i (bus_if.wr1_addr),
      .wr1_data_i (bus_if.wr1_data),
      .data_o     (data),
      .hit_o      (hit)
    );

    assign rd_data_w[k*XLEN +: XLEN] = data;
    assign rd_busy_w[k]              = busy_q[ra] & ~hit;
  end

  assign bus_if.rd_data  = rd_data_w;
  assign bus_if.rd_busy  = rd_busy_w;
  assign bus_if.busy     = busy_q;
  assign bus_if.dbg_data = regs_q[bus_if.dbg_sel];
endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Directed bench for rf_mp_scoreboard: reset, bypass, write priority, zero register, scoreboard.
module tb_rf_mp_scoreboard;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_mp_scoreboard_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

  rf_mp_scoreboard #(
    .XLEN     (32),
    .NREG     (32),
    .NRD      (2),
    .ZERO_REG (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr0_en      = 1'b0;
    bus.wr0_addr    = '0;
    bus.wr0_data    = '0;
    bus.wr1_en      = 1'b0;
    bus.wr1_addr    = '0;
    bus.wr1_data    = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
  endtask

  task automatic set_rd(input reg_idx_t p1, input reg_idx_t p0);
    bus.rd_addr = {p1, p0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    bus.dbg_sel = '0;

    // Asynchronous reset, swept over every index on both ports and debug
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 32'h0);
    for (int i = 0; i < 32; i++) begin
      reg_idx_t idx;
      idx         = reg_idx_t'(i);
      bus.dbg_sel = idx;
      set_rd(idx, idx);
      #1;
      check($sformatf("rst_dbg%0d", i), bus.dbg_data, 32'h0);
      check($sformatf("rst_rd0_%0d", i), bus.rd_data[31:0], 32'h0);
      check($sformatf("rst_rd1_%0d", i), bus.rd_data[63:32], 32'h0);
      check($sformatf("rst_rdbusy%0d", i), {30'h0, bus.rd_busy}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted while a write is pending: nothing commits
    @(negedge clk);
    bus.wr0_en   = 1'b1;
    bus.wr0_addr = 5'd4;
    bus.wr0_data = 32'hAAAA_AAAA;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    bus.dbg_sel = 5'd4;
    #1;
    check("rst_midwrite_dbg4", bus.dbg_data, 32'h0);

    // wr0 bypass then commit
    @(negedge clk);
    bus.wr0_en   = 1'b1;
    bus.wr0_addr = 5'd5;
    bus.wr0_data = 32'hDEAD_BEEF;
    set_rd(5'd0, 5'd5);
    bus.dbg_sel  = 5'd5;
    #1;
    check("byp_wr0_rd0", bus.rd_data[31:0], 32'hDEAD_BEEF);
    check("byp_wr0_dbg_precommit", bus.dbg_data, 32'h0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("commit_dbg5", bus.dbg_data, 32'hDEAD_BEEF);
    check("commit_rd5", bus.rd_data[31:0], 32'hDEAD_BEEF);

    // Both ports to the same index: wr1 wins
    @(negedge clk);
    bus.wr0_en   = 1'b1;
    bus.wr0_addr = 5'd7;
    bus.wr0_data = 32'h11;
    bus.wr1_en   = 1'b1;
    bus.wr1_addr = 5'd7;
    bus.wr1_data = 32'h22;
    set_rd(5'd7, 5'd5);
    bus.dbg_sel  = 5'd7;
    #1;
    check("prio_rd1", bus.rd_data[63:32], 32'h22);
    check("prio_rd0_other", bus.rd_data[31:0], 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("prio_dbg7", bus.dbg_data, 32'h22);

    // Zero register ignores writes, bypass and scoreboard set
    @(negedge clk);
    bus.wr0_en   = 1'b1;
    bus.wr0_addr = 5'd0;
    bus.wr0_data = 32'hFFFF_FFFF;
    bus.wr1_en   = 1'b1;
    bus.wr1_addr = 5'd0;
    bus.wr1_data = 32'hFFFF_FFFF;
    set_rd(5'd0, 5'd0);
    bus.dbg_sel  = 5'd0;
    #1;
    check("zero_rd0_byp", bus.rd_data[31:0], 32'h0);
    check("zero_rd1_byp", bus.rd_data[63:32], 32'h0);
    @(posedge clk);
    #1;
    idle();
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd0;
    #1;
    check("zero_dbg0", bus.dbg_data, 32'h0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("zero_busy", bus.busy, 32'h0);
    check("zero_rdbusy", {30'h0, bus.rd_busy}, 32'h0);

    // Scoreboard set, pending source, then cleared by wr1 with bypass
    @(negedge clk);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd9;
    @(posedge clk);
    #1;
    idle();
    set_rd(5'd9, 5'd0);
    #1;
    check("sb9_busy", bus.busy, 32'h0000_0200);
    check("sb9_rdbusy", {30'h0, bus.rd_busy}, 32'h2);
    @(negedge clk);
    bus.wr1_en   = 1'b1;
    bus.wr1_addr = 5'd9;
    bus.wr1_data = 32'h55;
    #1;
    check("sb9_rdbusy_wb", {30'h0, bus.rd_busy}, 32'h0);
    check("sb9_rd1_wb", bus.rd_data[63:32], 32'h55);
    check("sb9_busy_still", bus.busy, 32'h0000_0200);
    @(posedge clk);
    #1;
    idle();
    bus.dbg_sel = 5'd9;
    #1;
    check("sb9_busy_clr", bus.busy, 32'h0);
    check("sb9_dbg", bus.dbg_data, 32'h55);

    // Set and write the same index in one cycle: busy stays, data commits
    @(negedge clk);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd3;
    bus.wr0_en      = 1'b1;
    bus.wr0_addr    = 5'd3;
    bus.wr0_data    = 32'h33;
    @(posedge clk);
    #1;
    idle();
    set_rd(5'd0, 5'd3);
    bus.dbg_sel = 5'd3;
    #1;
    check("setwin_busy", bus.busy, 32'h0000_0008);
    check("setwin_dbg3", bus.dbg_data, 32'h33);
    check("setwin_rd0", bus.rd_data[31:0], 32'h33);
    check("setwin_rdbusy", {30'h0, bus.rd_busy}, 32'h1);

    // Async reset mid-cycle clears state before any clock edge
    @(negedge clk);
    bus.dbg_sel = 5'd5;
    rst = 1'b1;
    #1;
    check("arst_dbg5", bus.dbg_data, 32'h0);
    check("arst_busy", bus.busy, 32'h0);
    check("arst_rd0", bus.rd_data[31:0], 32'h0);
    #2 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_mp_scoreboard.md
Name: rf_mp_scoreboard

Overview:
Parametrised multi-port general-purpose register file for the pipelined CPU core, the successor to the single-write/two-read single-cycle RF. It provides configurable read-port count, two write ports with fixed priority, same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for hazard detection. It sits between decode/issue (read and scoreboard set) and writeback (write and scoreboard clear).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREG), register index width (derived, not overridden)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1 register 0 reads 0, ignores writes, is never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr0_en  in  1  write port 0 enable
wr0_addr  in  AW  write port 0 index
wr0_data  in  XLEN  write port 0 data
wr1_en  in  1  write port 1 enable (priority over port 0)
wr1_addr  in  AW  write port 1 index
wr1_data  in  XLEN  write port 1 data
rd_addr  in  NRD*AW  packed read indices, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NRD  port k source still pending
sb_set_en  in  1  mark destination register pending (issue)
sb_set_addr  in  AW  destination index to mark
busy  out  NREG  full scoreboard vector
dbg_sel  in  AW  debug register select
dbg_data  out  XLEN  debug read of committed state

Behaviour:
- Reset: async assert clears all registers and all busy bits to 0 immediately; rd_data/dbg_data then read 0, busy = 0, rd_busy = 0. Reset mid-cycle discards any in-flight write or set.
- Write: on rising clk, wrX_en stores wrX_data at wrX_addr; one-cycle commit latency.
- Both write ports enabled with same address: port 1 value stored, port 0 dropped.
- ZERO_REG=1: writes to index 0 ignored; reads of 0 return 0 on every port including dbg.
- Read: combinational, zero latency. Bypass: if wr1_en and wr1_addr==rd_addr[k] then wr1_data; else if wr0_en and match then wr0_data; else stored value. Index 0 with ZERO_REG never bypassed.
- dbg_data: committed array contents only, no bypass.
- Scoreboard, per register, updated on rising clk:
  - set when sb_set_en and sb_set_addr==i;
  - clear when any enabled write port targets i;
  - set and clear same index same cycle: set wins (newer producer issued);
  - index 0 never set when ZERO_REG=1.
- rd_busy[k] = busy[rd_addr[k]] AND NOT (any enabled write this cycle to rd_addr[k]); the bypassed value is the valid one.
- Out-of-range indices impossible (NREG power of two).
- No X propagation: all storage reset; outputs defined from reset.

Decomposition:
- Shared package rf_pkg: default XLEN/NREG constants, reg_idx_t typedef, ZERO_IDX constant.
- One natural sub-module rf_bypass_mux: per-read-port priority bypass select (stored data, wr0, wr1, zero), instantiated NRD times in a generate loop.

Test Plan:
- Reset, then read all ports of indices 0..31 -> all 0, busy == 0; assert rst mid-write -> value not committed.
- wr0 x5=0xDEADBEEF at cycle N, read x5 same cycle -> bypass 0xDEADBEEF; cycle N+1 dbg_sel=5 -> 0xDEADBEEF.
- wr0 x7=0x11, wr1 x7=0x22 same cycle -> rd 0x22 same cycle, dbg x7 = 0x22 after edge.
- Write x0=0xFFFFFFFF with ZERO_REG=1 -> rd and dbg of x0 stay 0; sb_set x0 -> busy[0] stays 0.
- sb_set x9, next cycle busy[9]=1 and rd_busy=1 for port reading x9; cycle with wr1 x9=0x55 -> rd_busy 0, rd_data 0x55; busy[9]=0 after edge.
- sb_set x3 and wr0 x3 in the same cycle -> busy[3]=1 after edge, x3 holds the written data.
